note_history_tubs: RTL and testbench
====================================

NOTE_HISTORY_TUBS -- requirements
Module: note_history_tubs

Interface
REQ-001 Parameter DEPTH, default 16, history entries stored (>= WIN).
REQ-002 Parameter WIN, default 8, entries presented per display window.
REQ-003 Parameter NOTE_W, default 5, note code width; codes 1..21 are valid notes, 0 is rest.
REQ-004 Parameter STABLE, default 4, consecutive identical samples needed to accept a note (>= 2).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 mode  input  2  0 IDLE, 1 PLAY, 2 RECORD, 3 REVIEW.
REQ-008 music  input  NOTE_W  live note code from keyboard/player.
REQ-009 clr  input  1  synchronous history clear, level-sampled.
REQ-010 scroll  input  1  single-cycle pulse; advances review window.
REQ-011 win_notes  output  WIN*NOTE_W  registered window; slot k at bits [k*NOTE_W +: NOTE_W], slot 0 = newest shown.
REQ-012 cur_oct  output  2  registered octave of focus note: 0 none, 1 low, 2 mid, 3 high.
REQ-013 cur_deg  output  3  registered scale degree 1..7 of focus note, 0 none.
REQ-014 count  output  clog2(DEPTH+1)  number of valid history entries.
REQ-015 full  output  1  high when count == DEPTH.
REQ-016 offset  output  clog2(DEPTH)  current review window start index.

Function
REQ-017 History SHALL be a shift buffer: entry 0 newest; push writes entry 0, moves entry i-1 to i, drops entry DEPTH-1.
REQ-018 Stability counter SHALL reset to 1 whenever sampled music differs from previous sample, else increment, saturating at STABLE.
REQ-019 Acceptance SHALL occur on the edge where the counter reaches STABLE; accepted value overwrites last_acc register.
REQ-020 Push SHALL occur only in RECORD, on acceptance, when accepted value is 1..21 and differs from last_acc.
REQ-021 Accepted rest (0) or code >21 SHALL update last_acc but never push; hence same note after a rest is pushed again.
REQ-022 count SHALL increment on push, saturating at DEPTH; full follows count.
REQ-023 Latency: first edge sampling new value = E1; push at E_STABLE; win_notes/count reflect it at E_STABLE+1.
REQ-024 win_notes slot k SHALL equal entry[offset+k] if offset+k < count, else 0.
REQ-025 In REVIEW, scroll SHALL set offset to offset+1, wrapping to 0 when offset+1 > max(count-WIN,0); count <= WIN keeps offset 0.
REQ-026 Entering REVIEW from any mode, and any cycle in IDLE, PLAY or RECORD, SHALL force offset to 0; scroll outside REVIEW ignored.
REQ-027 Focus note: PLAY/RECORD = sampled music; REVIEW = entry[offset] (0 if count == 0); IDLE = 0.
REQ-028 cur_oct: 1 for 1..7, 2 for 8..14, 3 for 15..21, else 0; cur_deg = ((n-1) mod 7)+1 for 1..21, else 0; one cycle after focus sample.
REQ-029 Mode change SHALL reset stability counter to 1 with current music as previous sample; last_acc unchanged.
REQ-030 clr SHALL zero all entries, count, offset and last_acc at next edge and takes priority over a same-cycle push or scroll.
REQ-031 History SHALL be retained across IDLE/PLAY/REVIEW; only clr or reset empties it.

Reset
REQ-032 rst low SHALL immediately clear entries, count, offset, last_acc, stability counter, previous sample, win_notes, cur_oct, cur_deg to 0; full low.
REQ-033 First post-reset edge SHALL treat music as new sample (counter = 1).
REQ-034 Reset asserted mid-acceptance SHALL discard the pending note; no push after release until a fresh STABLE run.

Verification (DEPTH=16, WIN=8, STABLE=4)
REQ-035 RECORD, music 5 held 4 cycles -> push at 4th edge; next cycle win_notes slot0=5, count=1, cur_oct=1, cur_deg=5.
REQ-036 RECORD, music 9 for 3 cycles then 0 -> no push, count unchanged; 9,0(4 cycles),9 -> two pushes of 9.
REQ-037 RECORD, 18 distinct stable notes -> count=16, full=1, entry 0 = last note, two oldest dropped.
REQ-038 REVIEW, count=12, 5 scroll pulses -> offset 1,2,3,4,0; at offset 4 slots 0..7 = entries 4..11.
REQ-039 REVIEW offset=2, clr and scroll same cycle -> count=0, offset=0, win_notes all 0, cur_oct=cur_deg=0.
REQ-040 Music 20 stable 3 cycles, rst pulsed low, music held 20 -> all outputs 0 during rst; push only after 4 post-reset edges.

Source files
------------

// File: rtl/note_history_tubs.sv
// note_history_tubs: debounced note recorder with a scrollable history window.
// Live note codes are accepted once they hold steady for STABLE samples; in
// RECORD mode accepted notes are shifted into a newest-first history, which
// REVIEW mode pages through WIN entries at a time.
module note_history_tubs #(
  parameter int DEPTH  = 16,
  parameter int WIN    = 8,
  parameter int NOTE_W = 5,
  parameter int STABLE = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int OW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [NOTE_W-1:0]     music,
  input  logic                  clr,
  input  logic                  scroll,
  output logic [WIN*NOTE_W-1:0] win_notes,
  output logic [1:0]            cur_oct,
  output logic [2:0]            cur_deg,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic [OW-1:0]         offset
);

  localparam int SW  = $clog2(STABLE + 1);
  localparam int CW1 = CW + 1;
  localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'(21);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_PLAY   = 2'd1,
    MODE_RECORD = 2'd2,
    MODE_REVIEW = 2'd3
  } mode_e;

  // Octave of a note code: 1..7 low, 8..14 mid, 15..21 high, anything else none.
  function automatic logic [1:0] note_oct(input logic [NOTE_W-1:0] n);
    logic [1:0] o;
    if (n >= NOTE_W'(1) && n <= NOTE_W'(7)) begin
      o = 2'd1;
    end else if (n >= NOTE_W'(8) && n <= NOTE_W'(14)) begin
      o = 2'd2;
    end else if (n >= NOTE_W'(15) && n <= NOTE_MAX) begin
      o = 2'd3;
    end else begin
      o = 2'd0;
    end
    return o;
  endfunction

  // Scale degree 1..7 of a note code, 0 for rest or out-of-range codes.
  function automatic logic [2:0] note_deg(input logic [NOTE_W-1:0] n);
    logic [NOTE_W-1:0] d;
    if (n >= NOTE_W'(1) && n <= NOTE_W'(7)) begin
      d = n;
    end else if (n >= NOTE_W'(8) && n <= NOTE_W'(14)) begin
      d = n - NOTE_W'(7);
    end else if (n >= NOTE_W'(15) && n <= NOTE_MAX) begin
      d = n - NOTE_W'(14);
    end else begin
      d = NOTE_W'(0);
    end
    return d[2:0];
  endfunction

  logic [NOTE_W-1:0]     hist_r [DEPTH];
  logic [NOTE_W-1:0]     prev_r;
  logic [NOTE_W-1:0]     last_acc_r;
  logic [SW-1:0]         stab_r;
  logic [SW-1:0]         stab_nxt_s;
  mode_e                 mode_r;
  mode_e                 mode_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic [OW-1:0]         offset_r;
  logic [OW-1:0]         offset_nxt_s;
  logic [CW-1:0]         max_off_s;
  logic [CW1-1:0]        off_inc_s;
  logic [CW1-1:0]        pos_s;
  logic                  full_r;
  logic [WIN*NOTE_W-1:0] win_r;
  logic [WIN*NOTE_W-1:0] win_s;
  logic [1:0]            oct_r;
  logic [2:0]            deg_r;
  logic [NOTE_W-1:0]     focus_s;
  logic                  mode_chg_s;
  logic                  same_s;
  logic                  accept_s;
  logic                  valid_s;
  logic                  push_s;

  // Debounce: run length of identical samples, acceptance and push decision.
  always_comb begin
    mode_s     = mode_e'(mode);
    mode_chg_s = (mode_s != mode_r);
    // A zero run length (just out of reset) makes any sample count as new.
    same_s     = (music == prev_r) && (stab_r != SW'(0));
    if (mode_chg_s || !same_s) begin
      stab_nxt_s = SW'(1);
    end else if (stab_r < SW'(STABLE)) begin
      stab_nxt_s = stab_r + SW'(1);
    end else begin
      stab_nxt_s = stab_r;
    end
    // Accept only on the transition into STABLE, not while saturated.
    accept_s = !mode_chg_s && same_s && (stab_r == SW'(STABLE - 1));
    valid_s  = (music >= NOTE_W'(1)) && (music <= NOTE_MAX);
    push_s   = accept_s && (mode_s == MODE_RECORD) && valid_s &&
               (music != last_acc_r) && !clr;
  end

  // Next count and review offset; offset only moves while staying in REVIEW.
  always_comb begin
    if (push_s && (count_r != CW'(DEPTH))) begin
      count_nxt_s = count_r + CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
    if (count_r > CW'(WIN)) begin
      max_off_s = count_r - CW'(WIN);
    end else begin
      max_off_s = CW'(0);
    end
    off_inc_s = CW1'(offset_r) + CW1'(1);
    if ((mode_s != MODE_REVIEW) || (mode_r != MODE_REVIEW)) begin
      offset_nxt_s = OW'(0);
    end else if (scroll) begin
      if (off_inc_s > CW1'(max_off_s)) begin
        offset_nxt_s = OW'(0);
      end else begin
        offset_nxt_s = offset_r + OW'(1);
      end
    end else begin
      offset_nxt_s = offset_r;
    end
  end

  // Window contents and focus note derived from the current history state.
  always_comb begin
    win_s   = {(WIN*NOTE_W){1'b0}};
    pos_s   = CW1'(0);
    focus_s = NOTE_W'(0);
    for (int k = 0; k < WIN; k++) begin
      pos_s = CW1'(offset_r) + CW1'(k);
      if (pos_s < CW1'(count_r)) begin
        win_s[k*NOTE_W +: NOTE_W] = hist_r[pos_s[OW-1:0]];
      end else begin
        win_s[k*NOTE_W +: NOTE_W] = NOTE_W'(0);
      end
    end
    case (mode_s)
      MODE_PLAY, MODE_RECORD: focus_s = music;
      MODE_REVIEW: begin
        if (CW'(offset_r) < count_r) begin
          focus_s = hist_r[offset_r];
        end else begin
          focus_s = NOTE_W'(0);
        end
      end
      default: focus_s = NOTE_W'(0);
    endcase
  end

  // Sample tracking: previous sample, run length and last seen mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= NOTE_W'(0);
      stab_r <= SW'(0);
      mode_r <= MODE_IDLE;
    end else begin
      prev_r <= music;
      stab_r <= stab_nxt_s;
      mode_r <= mode_s;
    end
  end

  // Last accepted value, used to suppress repeated pushes of the same note.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_acc_r <= NOTE_W'(0);
    end else if (clr) begin
      last_acc_r <= NOTE_W'(0);
    end else if (accept_s) begin
      last_acc_r <= music;
    end
  end

  // History shift buffer, entry count, full flag and review offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) hist_r[i] <= NOTE_W'(0);
      count_r  <= CW'(0);
      full_r   <= 1'b0;
      offset_r <= OW'(0);
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) hist_r[i] <= NOTE_W'(0);
      count_r  <= CW'(0);
      full_r   <= 1'b0;
      offset_r <= OW'(0);
    end else begin
      if (push_s) begin
        hist_r[0] <= music;
        for (int i = 1; i < DEPTH; i++) hist_r[i] <= hist_r[i-1];
      end
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      offset_r <= offset_nxt_s;
    end
  end

  // Registered display outputs: window and focus note octave/degree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r <= {(WIN*NOTE_W){1'b0}};
      oct_r <= 2'd0;
      deg_r <= 3'd0;
    end else begin
      win_r <= win_s;
      oct_r <= note_oct(focus_s);
      deg_r <= note_deg(focus_s);
    end
  end

  assign win_notes = win_r;
  assign cur_oct   = oct_r;
  assign cur_deg   = deg_r;
  assign count     = count_r;
  assign full      = full_r;
  assign offset    = offset_r;

endmodule

// File: tb/tb_note_history_tubs.sv
// tb_note_history_tubs: table-driven octave/degree checks through a
// scoreboard queue, plus hand-written record/review/clear/reset sequences.
module tb_note_history_tubs;
  localparam int DEPTH  = 16;
  localparam int WIN    = 8;
  localparam int NOTE_W = 5;
  localparam int STABLE = 4;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int OW     = $clog2(DEPTH);

  logic                  clk;
  logic                  rst;
  logic [1:0]            mode;
  logic [NOTE_W-1:0]     music;
  logic                  clr;
  logic                  scroll;
  logic [WIN*NOTE_W-1:0] win_notes;
  logic [1:0]            cur_oct;
  logic [2:0]            cur_deg;
  logic [CW-1:0]         count;
  logic                  full;
  logic [OW-1:0]         offset;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NOTE_W-1:0] note;
    logic [1:0]        oct;
    logic [2:0]        deg;
  } vec_t;

  vec_t vecs [10];
  vec_t sb   [$];

  note_history_tubs #(
    .DEPTH (DEPTH),
    .WIN   (WIN),
    .NOTE_W(NOTE_W),
    .STABLE(STABLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .music    (music),
    .clr      (clr),
    .scroll   (scroll),
    .win_notes(win_notes),
    .cur_oct  (cur_oct),
    .cur_deg  (cur_deg),
    .count    (count),
    .full     (full),
    .offset   (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int note, input int cycles);
    music = NOTE_W'(note);
    repeat (cycles) step();
  endtask

  function automatic int slot(input int k);
    return int'(win_notes[k*NOTE_W +: NOTE_W]);
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_win_any"}, int'(|win_notes), 0);
    check({tag, "_oct"}, int'(cur_oct), 0);
    check({tag, "_deg"}, int'(cur_deg), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_offset"}, int'(offset), 0);
  endtask

  task automatic do_scroll();
    scroll = 1'b1;
    step();
    scroll = 1'b0;
  endtask

  task automatic do_clear();
    clr   = 1'b1;
    music = NOTE_W'(0);
    step();
    clr   = 1'b0;
  endtask

  initial begin
    vec_t e;
    int   exp_off [5];

    vecs[0] = '{5'd0,  2'd0, 3'd0};
    vecs[1] = '{5'd1,  2'd1, 3'd1};
    vecs[2] = '{5'd7,  2'd1, 3'd7};
    vecs[3] = '{5'd8,  2'd2, 3'd1};
    vecs[4] = '{5'd14, 2'd2, 3'd7};
    vecs[5] = '{5'd15, 2'd3, 3'd1};
    vecs[6] = '{5'd21, 2'd3, 3'd7};
    vecs[7] = '{5'd22, 2'd0, 3'd0};
    vecs[8] = '{5'd31, 2'd0, 3'd0};
    vecs[9] = '{5'd12, 2'd2, 3'd5};
    exp_off = '{1, 2, 3, 4, 0};

    // Reset state
    rst    = 1'b1;
    mode   = 2'd0;
    music  = 5'd0;
    clr    = 1'b0;
    scroll = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) step();

    // PLAY: octave/degree mapping via scoreboard
    mode = 2'd1;
    for (int i = 0; i < 10; i++) begin
      music = vecs[i].note;
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      check($sformatf("play_oct_n%0d", e.note), int'(cur_oct), int'(e.oct));
      check($sformatf("play_deg_n%0d", e.note), int'(cur_deg), int'(e.deg));
    end
    check("play_no_push", int'(count), 0);

    // IDLE: focus is none
    mode  = 2'd0;
    music = 5'd7;
    step();
    check("idle_oct", int'(cur_oct), 0);
    check("idle_deg", int'(cur_deg), 0);

    // RECORD: 5 held STABLE cycles pushes on the 4th edge
    mode = 2'd2;
    hold(5, 3);
    check("rec5_no_early_push", int'(count), 0);
    step();
    check("rec5_count", int'(count), 1);
    step();
    check("rec5_slot0", slot(0), 5);
    check("rec5_oct", int'(cur_oct), 1);
    check("rec5_deg", int'(cur_deg), 5);

    // RECORD: short run discarded; rest re-arms the same note
    hold(9, 3);
    hold(0, 4);
    check("rec9_short_no_push", int'(count), 1);
    hold(9, 4);
    check("rec9_first_push", int'(count), 2);
    hold(9, 4);
    check("rec9_held_no_repush", int'(count), 2);
    hold(0, 4);
    check("rec_rest_no_push", int'(count), 2);
    hold(9, 4);
    check("rec9_after_rest", int'(count), 3);
    step();
    check("rec9_slot0", slot(0), 9);
    check("rec9_slot1", slot(1), 9);
    check("rec9_slot2", slot(2), 5);
    check("rec9_slot3", slot(3), 0);

    // REVIEW with count <= WIN: scroll keeps offset 0
    mode = 2'd3;
    step();
    do_scroll();
    check("rev_small_offset", int'(offset), 0);

    // RECORD 18 distinct notes: saturate at DEPTH, drop oldest
    mode = 2'd2;
    do_clear();
    check("clr_count", int'(count), 0);
    for (int n = 1; n <= 18; n++) begin
      hold(n, 4);
      if (n == 15) begin
        check("fill15_count", int'(count), 15);
        check("fill15_full", int'(full), 0);
      end
    end
    check("fill_count", int'(count), 16);
    check("fill_full", int'(full), 1);
    step();
    for (int k = 0; k < WIN; k++) check($sformatf("fill_slot%0d", k), slot(k), 18 - k);

    // REVIEW with 12 entries: offsets wrap after max(count-WIN,0)
    do_clear();
    check("clr2_full", int'(full), 0);
    for (int n = 1; n <= 12; n++) hold(n, 4);
    check("fill12_count", int'(count), 12);
    mode = 2'd3;
    step();
    check("rev_enter_offset", int'(offset), 0);
    for (int i = 0; i < 5; i++) begin
      do_scroll();
      check($sformatf("rev_scroll%0d_offset", i + 1), int'(offset), exp_off[i]);
      if (exp_off[i] == 4) begin
        step();
        for (int k = 0; k < WIN; k++) check($sformatf("rev_off4_slot%0d", k), slot(k), 8 - k);
        check("rev_off4_oct", int'(cur_oct), 2);
        check("rev_off4_deg", int'(cur_deg), 1);
      end
    end

    // Leaving REVIEW forces offset 0; history retained
    do_scroll();
    do_scroll();
    check("rev_offset2", int'(offset), 2);
    mode = 2'd1;
    step();
    check("play_offset_reset", int'(offset), 0);
    check("play_retain_count", int'(count), 12);
    mode = 2'd3;
    step();
    do_scroll();
    do_scroll();
    check("rev_again_offset2", int'(offset), 2);

    // clr wins over same-cycle scroll
    clr    = 1'b1;
    scroll = 1'b1;
    step();
    clr    = 1'b0;
    scroll = 1'b0;
    check("clrscr_count", int'(count), 0);
    check("clrscr_offset", int'(offset), 0);
    step();
    check("clrscr_win_any", int'(|win_notes), 0);
    check("clrscr_oct", int'(cur_oct), 0);
    check("clrscr_deg", int'(cur_deg), 0);

    // Reset mid-acceptance discards the pending note
    mode = 2'd2;
    hold(20, 3);
    check("pre_rst_oct", int'(cur_oct), 3);
    check("pre_rst_deg", int'(cur_deg), 6);
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) step();
    check("postrst_no_early_push", int'(count), 0);
    step();
    check("postrst_push", int'(count), 1);
    step();
    check("postrst_slot0", slot(0), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
